// File: rtl/gpio_debounce.sv
// Per-channel pin debouncer with a small register bus (STATE/THRESH/EDGE/MASK).
// Optional edge flags, mask and irq are built only when GPIO_DB_IRQ_EN is defined.
module gpio_debounce #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CH-1:0]    pin_in,
  input  logic             cs_,
  input  logic             as_,
  input  logic             rw,
  input  logic [1:0]       addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  output logic             rdy_,
  output logic [CH-1:0]    gpio_in_db
`ifdef GPIO_DB_IRQ_EN
  ,
  output logic             irq
`endif
);

  logic [CH-1:0]    r_sync1;
  logic [CH-1:0]    r_sync2;
  logic [CH-1:0]    r_stable;
  logic [CNT_W-1:0] r_thresh;
  logic [31:0]      r_rd_data;
  logic             r_rdy;
  logic [CH-1:0]    w_take;
  logic             w_access;
  logic             w_wr;
  logic             w_rd;
  logic [31:0]      w_rd_sel;
  logic             w_unused;

  assign w_access = ~cs_ & ~as_;
  assign w_wr     = w_access & ~rw;
  assign w_rd     = w_access & rw;
  assign w_unused = ^wr_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= pin_in;
      r_sync2 <= r_sync1;
    end
  end

  // The >= compare lets a lowered threshold take effect at once without wrapping.
  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;

    assign w_diff     = r_sync2[gi] ^ r_stable[gi];
    assign w_take[gi] = w_diff && (r_cnt >= r_thresh);

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt <= '0;
      end else if (!w_diff || w_take[gi]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stable <= '0;
    end else begin
      r_stable <= r_stable ^ w_take;
    end
  end

  assign gpio_in_db = r_stable;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_thresh <= CNT_W'(16);
    end else if (w_wr && addr == 2'd1) begin
      r_thresh <= wr_data[CNT_W-1:0];
    end
  end

`ifdef GPIO_DB_IRQ_EN
  logic [2*CH-1:0] r_edge;
  logic [2*CH-1:0] r_mask;
  logic [2*CH-1:0] w_set;
  logic [2*CH-1:0] w_clr;

  // Falls in the upper half, rises in the lower half; a new edge beats a same-cycle clear.
  assign w_set = {w_take & ~r_sync2, w_take & r_sync2};
  assign w_clr = (w_wr && addr == 2'd2) ? wr_data[2*CH-1:0] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_edge <= '0;
      r_mask <= '0;
    end else begin
      r_edge <= (r_edge & ~w_clr) | w_set;
      if (w_wr && addr == 2'd3) begin
        r_mask <= wr_data[2*CH-1:0];
      end
    end
  end

  assign irq = |(r_edge & r_mask);
`endif

  always_comb begin
    w_rd_sel = '0;
    case (addr)
      2'd0: w_rd_sel[CH-1:0]    = r_stable;
      2'd1: w_rd_sel[CNT_W-1:0] = r_thresh;
`ifdef GPIO_DB_IRQ_EN
      2'd2: w_rd_sel[2*CH-1:0]  = r_edge;
      2'd3: w_rd_sel[2*CH-1:0]  = r_mask;
`endif
      default: w_rd_sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdy     <= 1'b1;
      r_rd_data <= '0;
    end else begin
      r_rdy     <= ~w_access;
      r_rd_data <= w_rd ? w_rd_sel : '0;
    end
  end

  assign rdy_    = r_rdy;
  assign rd_data = r_rd_data;

endmodule

// File: tb/tb_gpio_debounce.sv
// Scoreboard bench for gpio_debounce: a cycle model predicts bus responses and the
// debounced outputs; a negedge monitor compares whatever the DUT presents.
module tb_gpio_debounce;
  localparam int CH    = 4;
  localparam int CNT_W = 8;

  logic          clk     = 1'b0;
  logic          reset   = 1'b0;
  logic [CH-1:0] pin_in  = '0;
  logic          cs_     = 1'b1;
  logic          as_     = 1'b1;
  logic          rw      = 1'b1;
  logic [1:0]    addr    = 2'd0;
  logic [31:0]   wr_data = '0;
  logic [31:0]   rd_data;
  logic          rdy_;
  logic [CH-1:0] gpio_in_db;
`ifdef GPIO_DB_IRQ_EN
  logic          irq;
`endif

  gpio_debounce #(.CH(CH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .pin_in     (pin_in),
    .cs_        (cs_),
    .as_        (as_),
    .rw         (rw),
    .addr       (addr),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .rdy_       (rdy_),
    .gpio_in_db (gpio_in_db)
`ifdef GPIO_DB_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pins are seen two edges late; a channel adopts the synced
  // value once it has disagreed for more than THRESH consecutive edges.
  logic [CH-1:0]   m_s1, m_s2, m_st;
  int unsigned     m_run [CH];
  int unsigned     m_thresh;
  logic [2*CH-1:0] m_edge, m_mask;
  int unsigned     exp_q [$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_st = '0;
      for (int i = 0; i < CH; i++) m_run[i] = 0;
      m_thresh = 16;
      m_edge = '0; m_mask = '0;
      exp_q.delete();
    end else begin
      logic [2*CH-1:0] set_b, clr_b;
      int unsigned rv;
      set_b = '0;
      clr_b = '0;
      if (!cs_ && !as_) begin
        rv = 0;
        if (rw) begin
          case (addr)
            2'd0: rv = 32'(m_st);
            2'd1: rv = m_thresh;
`ifdef GPIO_DB_IRQ_EN
            2'd2: rv = 32'(m_edge);
            2'd3: rv = 32'(m_mask);
`endif
            default: rv = 0;
          endcase
        end
        exp_q.push_back(rv);
      end
      for (int i = 0; i < CH; i++) begin
        if (m_s2[i] != m_st[i]) begin
          if (m_run[i] >= m_thresh) begin
            m_st[i] = m_s2[i];
            m_run[i] = 0;
            if (m_s2[i]) set_b[i] = 1'b1;
            else         set_b[CH+i] = 1'b1;
          end else begin
            m_run[i] = m_run[i] + 1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (!cs_ && !as_ && !rw) begin
        if (addr == 2'd1) m_thresh = wr_data & ((32'd1 << CNT_W) - 1);
`ifdef GPIO_DB_IRQ_EN
        if (addr == 2'd2) clr_b = wr_data[2*CH-1:0];
        if (addr == 2'd3) m_mask = wr_data[2*CH-1:0];
`endif
      end
      m_edge = (m_edge & ~clr_b) | set_b;
      m_s2 = m_s1;
      m_s1 = pin_in;
    end
  end

  // Monitor: a low rdy_ presents a bus response; debounced outputs are checked every cycle.
  always @(negedge clk) begin
    if (reset) begin
      int unsigned e;
      check("gpio_in_db", 32'(gpio_in_db), 32'(m_st));
`ifdef GPIO_DB_IRQ_EN
      check("irq", 32'(irq), 32'(|(m_edge & m_mask)));
`endif
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rdy_ on access", 32'(rdy_), 32'd0);
        check("rd_data", rd_data, e);
        $display("bus txn: rd_data=0x%0h expected=0x%0h", rd_data, e);
      end else begin
        check("rdy_ idle", 32'(rdy_), 32'd1);
        check("rd_data idle", rd_data, 32'd0);
      end
    end
  end

  // Called at a negedge; the access edge is the following posedge.
  task automatic bus(input logic r, input logic [1:0] a, input logic [31:0] d);
    cs_ = 1'b0; as_ = 1'b0; rw = r; addr = a; wr_data = d;
    @(negedge clk);
    cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; wr_data = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ra;
    logic        rr;
    logic [31:0] rd;

    idle(3);
    check("reset rdy_", 32'(rdy_), 32'd1);
    check("reset rd_data", rd_data, 32'd0);
    check("reset gpio_in_db", 32'(gpio_in_db), 32'd0);
    reset = 1'b1;
    idle(1);

    bus(1'b1, 2'd0, 0);
    bus(1'b1, 2'd1, 0);

    // Clean change with THRESH=3 must appear exactly six edges later.
    bus(1'b0, 2'd1, 32'd3);
    idle(2);
    pin_in = 4'h5;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) check("latency edge5", 32'(gpio_in_db), 32'h0);
      if (k == 6) check("latency edge6", 32'(gpio_in_db), 32'h5);
    end
    bus(1'b1, 2'd0, 0);

    // Three-cycle glitch is rejected.
    pin_in = 4'h4;
    idle(3);
    pin_in = 4'h5;
    idle(8);
    check("glitch rejected", 32'(gpio_in_db), 32'h5);
    bus(1'b1, 2'd2, 0);

`ifdef GPIO_DB_IRQ_EN
    pin_in = 4'h4;
    idle(8);
    bus(1'b0, 2'd2, 32'hFF);
    bus(1'b0, 2'd3, 32'h01);
    pin_in = 4'h5;
    idle(8);
    check("irq after rise", 32'(irq), 32'd1);
    bus(1'b1, 2'd2, 0);
    bus(1'b0, 2'd2, 32'h01);
    check("irq after clear", 32'(irq), 32'd0);
    bus(1'b1, 2'd2, 0);

    // Clear lands on the same edge that sets the ch0 rise flag.
    pin_in = 4'h4;
    idle(8);
    bus(1'b0, 2'd2, 32'hFF);
    pin_in = 4'h5;
    idle(5);
    bus(1'b0, 2'd2, 32'h01);
    check("set beats clear irq", 32'(irq), 32'd1);
    bus(1'b1, 2'd2, 0);
`endif

    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        pin_in = CH'($urandom());
        idle($urandom_range(0, 8));
      end else begin
        ra = 2'($urandom_range(0, 3));
        rr = 1'($urandom_range(0, 1));
        rd = (ra == 2'd1) ? $urandom_range(0, 6) : $urandom();
        bus(rr, ra, rd);
      end
    end

    // Lowering THRESH mid-count lets the change through on the very next edge.
    bus(1'b0, 2'd1, 32'd0);
    pin_in = 4'h0;
    idle(6);
    bus(1'b0, 2'd1, 32'd200);
    pin_in = 4'hA;
    idle(20);
    bus(1'b0, 2'd1, 32'd2);
    check("thresh drop before", 32'(gpio_in_db), 32'h0);
    idle(1);
    check("thresh drop after", 32'(gpio_in_db), 32'hA);

    // Reset in the middle of a count.
    bus(1'b0, 2'd1, 32'd10);
    pin_in = 4'h5;
    idle(5);
    reset = 1'b0;
    idle(2);
    check("mid reset gpio", 32'(gpio_in_db), 32'h0);
    reset = 1'b1;
    bus(1'b1, 2'd2, 0);
    bus(1'b1, 2'd1, 0);
    idle(25);
    bus(1'b1, 2'd0, 0);
    bus(1'b1, 2'd2, 0);
    idle(3);
    check("queue drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gpio_debounce.md
GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 Parameter CH, default 4, number of debounced input channels; its output feeds gpio_in of the GPIO block.
REQ-002 Parameter CNT_W, default 8, width of each per-channel debounce counter and of the threshold register.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 pin_in  input  CH  raw, asynchronous external pins.
REQ-006 cs_  input  1  chip select, active-low.
REQ-007 as_  input  1  address strobe, active-low.
REQ-008 rw  input  1  1 = read, 0 = write.
REQ-009 addr  input  2  register select: 0 STATE, 1 THRESH, 2 EDGE, 3 MASK.
REQ-010 wr_data  input  32  write data.
REQ-011 rd_data  output  32  registered read data.
REQ-012 rdy_  output  1  registered ready, active-low.
REQ-013 gpio_in_db  output  CH  debounced stable pin value.
REQ-014 irq  output  1  edge interrupt (present only with GPIO_DB_IRQ_EN).

Function
REQ-015 Each pin_in bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-016 Per channel: when sync != stable and cnt < thresh, cnt SHALL increment by 1.
REQ-017 Per channel: when sync != stable and cnt >= thresh, stable SHALL take the sync value and cnt SHALL clear in that cycle.
REQ-018 Per channel: when sync == stable, cnt SHALL clear to 0, so any glitch shorter than thresh+1 cycles is rejected.
REQ-019 The compare SHALL use >=, so lowering THRESH mid-count never wraps a counter; THRESH=0 gives stable = sync after 1 cycle.
REQ-020 Latency from a clean pin change to gpio_in_db SHALL be THRESH+3 rising edges.
REQ-021 gpio_in_db SHALL equal the stable register directly, with no extra stage.
REQ-022 A bus access SHALL be when cs_=0 and as_=0; rdy_ SHALL go low the following cycle and return high otherwise.
REQ-023 A read SHALL load rd_data with the selected register, zero-extended, on the access edge; rd_data SHALL be 0 on writes and idle cycles.
REQ-024 STATE (addr 0) SHALL be read-only; writes to it are ignored.
REQ-025 THRESH (addr 1) SHALL be read/write over bits [CNT_W-1:0].
REQ-026 EDGE (addr 2) SHALL hold sticky flags: bit i is rise on channel i, bit CH+i is fall; writing 1 clears a bit, writing 0 has no effect.
REQ-027 When a hardware edge and a clear hit the same EDGE bit in one cycle, the set SHALL win.
REQ-028 MASK (addr 3) SHALL be read/write over bits [2CH-1:0].
REQ-029 irq SHALL be the combinational OR of (EDGE & MASK).

Reset
REQ-030 reset low SHALL asynchronously clear the sync flops, stable, cnt, EDGE, MASK and rd_data, set rdy_=1 and set THRESH=16.
REQ-031 Reset asserted mid-debounce SHALL abort the count, and no edge flag SHALL set on the reset release.

Configuration
REQ-032 With GPIO_DB_IRQ_EN defined, the EDGE and MASK registers and the irq port SHALL exist as described above.
REQ-033 Without GPIO_DB_IRQ_EN, the irq port, the EDGE and MASK registers and the edge logic SHALL be absent; addresses 2 and 3 SHALL read 0 and ignore writes.

Verification
REQ-034 Reset, then read addr 0 and addr 1 -> rdy_ low the next cycle; rd_data 0x0 then 0x10; gpio_in_db=0.
REQ-035 Write THRESH=3, then drive pin_in=4'h5 and hold -> gpio_in_db=4'h5 exactly 6 edges later; read STATE gives 0x5.
REQ-036 THRESH=3, pulse pin_in[0] high for 3 cycles -> gpio_in_db unchanged, EDGE=0.
REQ-037 (IRQ_EN) MASK=0x01, debounced rise on ch0 -> EDGE=0x01, irq=1; write EDGE=0x01 -> EDGE=0, irq=0.
REQ-038 (IRQ_EN) Clear the ch0 rise bit in the same cycle a new rise sets it -> bit stays 1.
REQ-039 THRESH=200, mid-count write THRESH=2 -> stable updates on the next cycle, with no counter wrap.
